// File: rtl/fp_align_ctrl.sv
// Exponent-alignment sequencer for the FP adder: picks the big/small operand,
// drives the shared right-shifter with the small fraction and hands off aligned mantissas.
module fp_align_ctrl #(
    parameter bit TIE_BY_FRAC = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] opA,
    input  logic [31:0] opB,
    output logic [22:0] sh_num,
    output logic [7:0]  sh_qtt,
    input  logic [25:0] sh_result,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  out_exp,
    output logic [25:0] out_mantBig,
    output logic [25:0] out_mantSmall,
    output logic        out_signBig,
    output logic        out_signSmall,
    output logic        out_swap,
    output logic        busy,
    output logic [1:0]  dbg_state_o
);

    // in_valid/in_ready and out_valid/out_ready: a transfer happens on a rising
    // edge where both are high; valid holds its payload until that edge.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CMP   = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t      state_q;
    logic [31:0] a_q, b_q;
    logic        in_ready_q, out_valid_q, busy_q;
    logic        swap_q, sign_big_q, sign_small_q;
    logic [7:0]  exp_q, sh_qtt_q;
    logic [22:0] sh_num_q;
    logic [25:0] mant_big_q, mant_small_q;

    logic [7:0]  a_exp, b_exp, big_exp_c, small_exp_c;
    logic [22:0] a_frac, b_frac;
    logic        a_is_big;
    logic [31:0] big_c, small_c, big_s, small_s;

    assign a_exp  = a_q[30:23];
    assign b_exp  = b_q[30:23];
    assign a_frac = a_q[22:0];
    assign b_frac = b_q[22:0];

    // Exponent decides; on a tie either the larger fraction or A wins.
    assign a_is_big = (a_exp > b_exp) ||
                      ((a_exp == b_exp) && (!TIE_BY_FRAC || (a_frac >= b_frac)));

    assign big_c       = a_is_big ? a_q : b_q;
    assign small_c     = a_is_big ? b_q : a_q;
    assign big_exp_c   = big_c[30:23];
    assign small_exp_c = small_c[30:23];

    // After CMP the selection is carried by swap_q.
    assign big_s   = swap_q ? b_q : a_q;
    assign small_s = swap_q ? a_q : b_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            a_q          <= '0;
            b_q          <= '0;
            in_ready_q   <= 1'b1;
            out_valid_q  <= 1'b0;
            busy_q       <= 1'b0;
            swap_q       <= 1'b0;
            sign_big_q   <= 1'b0;
            sign_small_q <= 1'b0;
            exp_q        <= '0;
            sh_qtt_q     <= '0;
            sh_num_q     <= '0;
            mant_big_q   <= '0;
            mant_small_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        a_q        <= opA;
                        b_q        <= opB;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                        state_q    <= CMP;
                    end
                end
                CMP: begin
                    swap_q       <= !a_is_big;
                    exp_q        <= big_exp_c;
                    sign_big_q   <= big_c[31];
                    sign_small_q <= small_c[31];
                    sh_num_q     <= small_c[22:0];
                    sh_qtt_q     <= big_exp_c - small_exp_c;
                    state_q      <= SHIFT;
                end
                SHIFT: begin
                    // A zero exponent field flushes that operand to a zero mantissa.
                    mant_big_q   <= (big_s[30:23] == 8'd0) ? 26'd0 : {1'b1, big_s[22:0], 2'b00};
                    mant_small_q <= (small_s[30:23] == 8'd0) ? 26'd0 : sh_result;
                    out_valid_q  <= 1'b1;
                    state_q      <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        busy_q      <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready      = in_ready_q;
    assign out_valid     = out_valid_q;
    assign busy          = busy_q;
    assign sh_num        = sh_num_q;
    assign sh_qtt        = sh_qtt_q;
    assign out_exp       = exp_q;
    assign out_mantBig   = mant_big_q;
    assign out_mantSmall = mant_small_q;
    assign out_signBig   = sign_big_q;
    assign out_signSmall = sign_small_q;
    assign out_swap      = swap_q;
    assign dbg_state_o   = state_q;

endmodule
